multififo_compact: RTL and testbench
====================================

# multififo_compact

Parametrised multi-port FIFO with independent push and pop widths. Each cycle it accepts a sparse set of input lanes, compacts them in ascending lane order, and presents up to OUT_PORT_NUM oldest entries first-word-fall-through. It extends the fixed-width multififo with:
- separate input/output port counts,
- non-contiguous input valid masks,
- an almost-full watermark,
- occupancy and accept-count outputs.

It sits between the fetch/decode and rename stages, where the producer and consumer bundle widths differ.

## Interface
- IN_PORT_NUM, 4, number of push lanes (>=1)
- OUT_PORT_NUM, 4, number of pop lanes (>=1)
- WIDTH, 32, entry width in bits
- DEPTH, 16, entry count; power of two, >= max(IN_PORT_NUM, OUT_PORT_NUM)
- ALMOST_FULL_LEVEL, 12, almost_full asserts when used_count >= this value (1..DEPTH)
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- data_in  in  WIDTH x IN_PORT_NUM  push data per lane
- data_in_valid  in  IN_PORT_NUM  lanes offering data, any bit pattern
- data_in_accept  out  IN_PORT_NUM  lanes that are written if push=1 (combinational)
- push_accept_num  out  $clog2(DEPTH)+1  popcount(data_in_accept) when push=1, else 0
- push  in  1  commit accepted lanes this cycle
- flush  in  1  discard all contents
- full  out  1  used_count == DEPTH
- almost_full  out  1  used_count >= ALMOST_FULL_LEVEL
- used_count  out  $clog2(DEPTH)+1  current occupancy
- data_out  out  WIDTH x OUT_PORT_NUM  lane k = k-th oldest entry
- data_out_valid  out  OUT_PORT_NUM  thermometer, min(used_count, OUT_PORT_NUM) low bits set
- data_pop_valid  in  OUT_PORT_NUM  lanes the consumer takes
- pop  in  1  commit pops this cycle
- empty  out  1  used_count == 0

## Operation
- Pointers: wptr and rptr are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - used_count = wptr - rptr.
  - full when the low bits are equal and the MSBs differ.
  - Storage index is the low $clog2(DEPTH) bits.
- free_space = DEPTH - used_count, computed from the registered state at the start of the cycle. A pop in the same cycle does not create push room.
- Push compaction:
  - rank(k) = number of set data_in_valid bits below lane k.
  - data_in_accept[k] = data_in_valid[k] && rank(k) < free_space.
  - When push=1, lane k is written to mem[wptr+rank(k)] and wptr advances by push_accept_num.
  - Lanes that are not accepted are dropped. The producer re-offers them.
- Pop:
  - pop_num = number of leading ones (from lane 0) of data_out_valid & data_pop_valid.
  - Bits after the first zero are ignored.
  - When pop=1, rptr advances by pop_num. A pop when empty is a no-op.
- Read: data_out[k] = mem[rptr+k] combinationally. Lanes with data_out_valid[k]=0 carry don't-care data.
- Priority: rst > flush > push/pop. rst or flush sets wptr=rptr=0 at the next edge. The push and pop of that cycle are discarded.
- Push and pop in the same cycle are independent. used_count_next = used_count + push_accept_num - pop_num.
- Reset values:
  - empty=1, full=0, almost_full=0, used_count=0.
  - data_out_valid=0, data_in_accept=data_in_valid (when DEPTH>=IN_PORT_NUM every valid lane fits).
  - push_accept_num = popcount(valid) if push=1, else 0.
  - data_out is undefined.
- Storage is not reset. Pointers alone define validity.

## Timing
- Push to visibility: an entry written at edge N appears on data_out and data_out_valid in the cycle after edge N. No bypass of same-cycle data.
- Status update: full, empty, almost_full and used_count are functions of the pointers and update one edge after the push/pop/flush that caused the change.
- Combinational paths:
  - data_in_accept and push_accept_num depend on data_in_valid, push and state, with zero latency.
  - data_pop_valid affects only the pointer update.
- At full, data_in_accept=0 for all lanes. Pop of up to OUT_PORT_NUM entries in that cycle is still honoured.
- Wrap-around is seamless: a multi-lane push or pop that crosses index DEPTH-1 → 0 behaves identically to one that does not.

## Test plan
- Reset: assert rst 2 cycles with push=1, valid=4'b1111 → empty=1, full=0, used_count=0, data_out_valid=0; mid-run rst with used_count=9 → used_count=0, empty=1 next cycle.
- Sparse push: valid=4'b1010, data_in[1]=0xA, data_in[3]=0xB, push=1 → accept=4'b1010, push_accept_num=2; next cycle data_out[0]=0xA, data_out[1]=0xB, data_out_valid=4'b0011, used_count=2.
- Near full: used_count=14, valid=4'b1111, push=1, pop=1 with pop_num=1 → accept=4'b0011, push_accept_num=2; next cycle used_count=15, almost_full=1, full=0.
- Full: used_count=16, valid=4'b1111, push=1, pop=1, data_pop_valid=4'b1111 → accept=0, push_accept_num=0; next cycle used_count=12, full=0, almost_full=1.
- Non-contiguous pop: used_count=4, data_pop_valid=4'b1011, pop=1 → pop_num=2; next cycle data_out[0] = the formerly third-oldest entry, used_count=2.
- Wrap and flush: random valid masks pushing 0..99 with random pops, scoreboarded in order across 6+ wraps; then flush=1 with push=1 and pop=1 → next cycle empty=1, used_count=0, and no flushed value ever reappears.

Source files
------------

// File: rtl/multififo_compact_if.sv
// multififo_compact_if: producer/consumer bundle of the compacting FIFO.
// master = environment side, slave = FIFO side; clk/rst stay outside.
interface multififo_compact_if #(
  parameter int IN_PORT_NUM  = 4,
  parameter int OUT_PORT_NUM = 4,
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [IN_PORT_NUM-1:0][WIDTH-1:0]  data_in;
  logic [IN_PORT_NUM-1:0]             data_in_valid;
  logic [IN_PORT_NUM-1:0]             data_in_accept;
  logic [CW-1:0]                      push_accept_num;
  logic                               push;
  logic                               flush;
  logic                               full;
  logic                               almost_full;
  logic [CW-1:0]                      used_count;
  logic [OUT_PORT_NUM-1:0][WIDTH-1:0] data_out;
  logic [OUT_PORT_NUM-1:0]            data_out_valid;
  logic [OUT_PORT_NUM-1:0]            data_pop_valid;
  logic                               pop;
  logic                               empty;

  modport master (
    output data_in, data_in_valid, push, flush,
    output data_pop_valid, pop,
    input  data_in_accept, push_accept_num,
    input  full, almost_full, used_count,
    input  data_out, data_out_valid, empty
  );

  modport slave (
    input  data_in, data_in_valid, push, flush,
    input  data_pop_valid, pop,
    output data_in_accept, push_accept_num,
    output full, almost_full, used_count,
    output data_out, data_out_valid, empty
  );
endinterface

// File: rtl/multififo_compact.sv
// multififo_compact: multi-lane FIFO, sparse push lanes compacted in order,
// FWFT multi-lane pop. Ports: clk, rst (sync, high), bus (slave modport).
module multififo_compact #(
  parameter int IN_PORT_NUM       = 4,
  parameter int OUT_PORT_NUM      = 4,
  parameter int WIDTH             = 32,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input logic                 clk,
  input logic                 rst,
  multififo_compact_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

  logic [PW-1:0] used;
  logic [PW-1:0] free;
  logic [PW-1:0] cnt;
  logic [PW-1:0] acc_num;
  logic [PW-1:0] pop_num;
  logic          run;
  logic [IN_PORT_NUM-1:0][PW-1:0] rank;
  logic [IN_PORT_NUM-1:0]         accept;
  logic [OUT_PORT_NUM-1:0]        out_valid;

  // Pointers carry one extra wrap bit, so the difference is the occupancy.
  assign used = wptr_q - rptr_q;
  assign free = PW'(DEPTH) - used;

  // rank = valid lanes below; a lane fits if its rank is below free room.
  always_comb begin
    cnt     = '0;
    acc_num = '0;
    rank    = '0;
    accept  = '0;
    for (int k = 0; k < IN_PORT_NUM; k++) begin
      rank[k]   = cnt;
      accept[k] = bus.data_in_valid[k] && (cnt < free);
      if (bus.data_in_valid[k]) cnt = cnt + PW'(1);
      if (accept[k]) acc_num = acc_num + PW'(1);
    end
  end

  // Pop count stops at the first lane not both valid and taken.
  always_comb begin
    pop_num   = '0;
    run       = 1'b1;
    out_valid = '0;
    bus.data_out = '0;
    for (int k = 0; k < OUT_PORT_NUM; k++) begin
      out_valid[k]    = PW'(k) < used;
      bus.data_out[k] = mem_q[rptr_q[AW-1:0] + AW'(k)];
      if (run && out_valid[k] && bus.data_pop_valid[k])
        pop_num = pop_num + PW'(1);
      else
        run = 1'b0;
    end
  end

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (bus.push) begin
      wptr_d = wptr_q + acc_num;
      for (int k = 0; k < IN_PORT_NUM; k++) begin
        if (accept[k])
          mem_d[wptr_q[AW-1:0] + rank[k][AW-1:0]] = bus.data_in[k];
      end
    end
    if (bus.pop) rptr_d = rptr_q + pop_num;
    if (bus.flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
    mem_q <= mem_d;
  end

  assign bus.data_in_accept  = accept;
  assign bus.push_accept_num = bus.push ? acc_num : '0;
  assign bus.data_out_valid  = out_valid;
  assign bus.used_count      = used;
  assign bus.full            = used == PW'(DEPTH);
  assign bus.almost_full     = used >= PW'(ALMOST_FULL_LEVEL);
  assign bus.empty           = used == '0;
endmodule

// File: tb/tb_multififo_compact.sv
// tb_multififo_compact: scoreboard bench; driver models occupancy and
// acceptance, monitor checks FWFT data and retires popped entries.
module tb_multififo_compact;
  localparam int IN  = 4;
  localparam int OUT = 4;
  localparam int W   = 32;
  localparam int D   = 16;
  localparam int AF  = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multififo_compact_if #(
    .IN_PORT_NUM(IN), .OUT_PORT_NUM(OUT),
    .WIDTH(W), .DEPTH(D)
  ) bus ();

  multififo_compact #(
    .IN_PORT_NUM(IN), .OUT_PORT_NUM(OUT),
    .WIDTH(W), .DEPTH(D), .ALMOST_FULL_LEVEL(AF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int committed = 0;
  int nv = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic check_status();
    int sz;
    logic [OUT-1:0] th;
    sz = exp_q.size();
    th = '0;
    for (int k = 0; k < OUT; k++) if (k < sz) th[k] = 1'b1;
    chk("used_count", 64'(bus.used_count), 64'(sz));
    chk("empty", 64'(bus.empty), 64'(sz == 0));
    chk("full", 64'(bus.full), 64'(sz == D));
    chk("almost_full", 64'(bus.almost_full), 64'(sz >= AF));
    chk("data_out_valid", 64'(bus.data_out_valid), 64'(th));
    committed = sz;
  endtask

  task automatic step(input logic [IN-1:0] v, input bit p, input bit po,
                      input logic [OUT-1:0] pm, input bit fl, input bit rs);
    int r;
    int free;
    int en;
    logic [IN-1:0] ea;
    check_status();
    r = 0;
    for (int k = 0; k < IN; k++) begin
      if (v[k]) begin
        bus.data_in[k] = nv + r;
        r++;
      end else begin
        bus.data_in[k] = $urandom;
      end
    end
    bus.data_in_valid  = v;
    bus.push           = p;
    bus.pop            = po;
    bus.data_pop_valid = pm;
    bus.flush          = fl;
    rst                = rs;
    #1;
    free = D - committed;
    ea = '0;
    en = 0;
    r  = 0;
    for (int k = 0; k < IN; k++) begin
      if (v[k]) begin
        if (r < free) begin
          ea[k] = 1'b1;
          en++;
        end
        r++;
      end
    end
    chk("accept", 64'(bus.data_in_accept), 64'(ea));
    chk("accept_num", 64'(bus.push_accept_num), 64'(p ? en : 0));
    if (fl || rs) begin
      exp_q.delete();
    end else if (p) begin
      for (int i = 0; i < en; i++) exp_q.push_back(nv + i);
    end
    if (p) nv += en;
    @(posedge clk);
    #1;
  endtask

  // Monitor: FWFT lanes must match the oldest entries; popped ones retire.
  always @(negedge clk) begin : monitor
    int lim;
    int pn;
    bit run;
    if (mon_en && !rst && !bus.flush) begin
      lim = (committed < OUT) ? committed : OUT;
      for (int k = 0; k < lim; k++)
        chk("data_out", 64'(bus.data_out[k]), 64'(exp_q[k]));
      if (bus.pop) begin
        pn  = 0;
        run = 1'b1;
        for (int k = 0; k < OUT; k++) begin
          if (run && k < lim && bus.data_pop_valid[k]) pn++;
          else run = 1'b0;
        end
        repeat (pn) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [IN-1:0] v;
    int r;
    rst                = 1'b1;
    bus.push           = 1'b1;
    bus.data_in_valid  = 4'b1111;
    bus.data_in        = '0;
    bus.pop            = 1'b0;
    bus.flush          = 1'b0;
    bus.data_pop_valid = '0;
    @(posedge clk);
    #1;
    chk("rst_accept", 64'(bus.data_in_accept), 64'hF);
    chk("rst_accept_num", 64'(bus.push_accept_num), 64'd4);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    nv = 10;
    step(4'b1010, 1, 0, 4'b0000, 0, 0);
    step(4'b0000, 0, 1, 4'b1111, 0, 0);

    nv = 1000;
    step(4'b1111, 1, 0, 4'b0000, 0, 0);
    step(4'b1111, 1, 0, 4'b0000, 0, 0);
    step(4'b1111, 1, 0, 4'b0000, 0, 0);
    step(4'b0011, 1, 0, 4'b0000, 0, 0);
    step(4'b1111, 1, 1, 4'b0001, 0, 0);
    step(4'b0001, 1, 0, 4'b0000, 0, 0);
    step(4'b1111, 1, 1, 4'b1111, 0, 0);
    step(4'b0000, 0, 1, 4'b1111, 0, 0);
    step(4'b0000, 0, 1, 4'b1111, 0, 0);
    step(4'b0000, 0, 1, 4'b1011, 0, 0);
    step(4'b0000, 0, 1, 4'b1111, 0, 0);

    nv = 0;
    for (int it = 0; it < 3000 && nv < 100; it++) begin
      v = 4'($urandom);
      r = 0;
      for (int k = 0; k < IN; k++) begin
        if (v[k]) begin
          if (nv + r >= 100) v[k] = 1'b0;
          else r++;
        end
      end
      step(v, ($urandom % 4) != 0, ($urandom % 2) == 1,
           4'($urandom), 0, 0);
    end
    chk("random_progress", 64'(nv), 64'd100);
    repeat (6) step(4'b0000, 0, 1, 4'b1111, 0, 0);

    nv = 2000;
    step(4'b1111, 1, 0, 4'b0000, 0, 0);
    step(4'b1111, 1, 0, 4'b0000, 0, 0);
    step(4'b0001, 1, 0, 4'b0000, 0, 0);
    step(4'b1111, 1, 1, 4'b1111, 0, 1);
    step(4'b0000, 0, 0, 4'b0000, 0, 0);

    nv = 3000;
    step(4'b1111, 1, 0, 4'b0000, 0, 0);
    step(4'b0111, 1, 0, 4'b0000, 0, 0);
    step(4'b1111, 1, 1, 4'b1111, 1, 0);
    step(4'b0101, 1, 0, 4'b0000, 0, 0);
    step(4'b1111, 1, 1, 4'b0001, 0, 0);
    repeat (3) step(4'b0000, 0, 1, 4'b1111, 0, 0);
    step(4'b0000, 0, 0, 4'b0000, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
